// File: rtl/mem_arbiter.sv
// Arbitrates one single-port RAM between an instruction fetch port and a data port.
// Data normally wins; a saturating starvation counter forces an instruction grant.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        mem_err
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic             dreq;
  logic             ram_done;
  logic             istarved;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c >= CNT_MAX) return CNT_MAX;
    return c + CNT_W'(1);
  endfunction

  assign dreq     = dREN | dWEN;
  assign ram_done = (ramstate == RAM_ACCESS);
  assign istarved = (starve_cnt == CNT_MAX);

  // Both read ports see the RAM bus directly; only the completing side samples it.
  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if ((state != IDLE) && (ramstate == RAM_ERROR)) mem_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    case (state)
      IDLE: begin
        if (iREN && (!dreq || istarved)) begin
          state_nxt  = IGRANT;
          starve_nxt = '0;
        end else if (dreq) begin
          state_nxt  = DGRANT;
          starve_nxt = iREN ? sat_inc(starve_cnt) : '0;
        end else if (!iREN) begin
          starve_nxt = '0;
        end
      end
      // Completion always drops back to IDLE so a held request is re-arbitrated.
      DGRANT: begin
        if (!dreq || ram_done) state_nxt = IDLE;
      end
      IGRANT: begin
        if (!iREN || ram_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = iREN;
    dwait    = dreq;
    case (state)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = ~ram_done;
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        iwait   = ~ram_done;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random
// traffic compared every cycle against an ownership/fairness model.
module tb_mem_arbiter;

  localparam int SM = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, mem_err;

  int n_checks = 0;
  int n_err    = 0;
  bit armed    = 1'b0;

  mem_arbiter #(.STARVE_MAX(SM)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the RAM (0 nobody, 1 data, 2 instruction), how many data
  // grants the waiting instruction side has been passed over for, sticky error.
  int owner = 0;
  int skips = 0;
  bit err   = 1'b0;

  always @(posedge CLK) begin
    bit dq;
    dq = dREN | dWEN;
    if (RST) begin
      owner = 0; skips = 0; err = 1'b0;
    end else begin
      if (owner != 0 && ramstate == 2'd3) err = 1'b1;
      case (owner)
        0: begin
          if (iREN && (!dq || skips >= SM)) begin
            owner = 2; skips = 0;
          end else if (dq) begin
            owner = 1;
            skips = iREN ? ((skips + 1 > SM) ? SM : skips + 1) : 0;
          end else if (!iREN) begin
            skips = 0;
          end
        end
        1: if (!dq || ramstate == 2'd2) owner = 0;
        default: if (!iREN || ramstate == 2'd2) owner = 0;
      endcase
    end
  end

  always @(negedge CLK) begin
    #2;
    if (armed) begin
      bit done;
      done = (ramstate == 2'd2);
      check("iload", iload, ramload);
      check("dload", dload, ramload);
      check("mem_err", {31'd0, mem_err}, {31'd0, err});
      case (owner)
        0: begin
          check("idle_ramREN", {31'd0, ramREN}, 32'd0);
          check("idle_ramWEN", {31'd0, ramWEN}, 32'd0);
          check("idle_iwait", {31'd0, iwait}, {31'd0, iREN});
          check("idle_dwait", {31'd0, dwait}, {31'd0, dREN | dWEN});
        end
        1: begin
          check("d_ramaddr", ramaddr, daddr);
          check("d_ramstore", ramstore, dstore);
          check("d_ramWEN", {31'd0, ramWEN}, {31'd0, dWEN});
          check("d_ramREN", {31'd0, ramREN}, {31'd0, dREN & ~dWEN});
          check("d_dwait", {31'd0, dwait}, {31'd0, ~done});
          check("d_iwait", {31'd0, iwait}, {31'd0, iREN});
        end
        default: begin
          check("i_ramaddr", ramaddr, iaddr);
          check("i_ramstore", ramstore, 32'd0);
          check("i_ramREN", {31'd0, ramREN}, 32'd1);
          check("i_ramWEN", {31'd0, ramWEN}, 32'd0);
          check("i_iwait", {31'd0, iwait}, {31'd0, ~done});
          check("i_dwait", {31'd0, dwait}, {31'd0, dREN | dWEN});
        end
      endcase
    end
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic quiet();
    iREN = 0; dREN = 0; dWEN = 0; ramstate = 2'd0;
  endtask

  initial begin
    logic [7:0] got[$];
    logic [7:0] want[6];
    RST = 1; quiet();
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    step(); step();
    RST = 0; armed = 1'b1;
    #3;
    check("rst_mem_err", {31'd0, mem_err}, 32'd0);
    check("rst_ramREN", {31'd0, ramREN}, 32'd0);
    check("rst_iwait", {31'd0, iwait}, 32'd0);

    // Instruction fetch, ACCESS on second grant cycle
    step(); iREN = 1; iaddr = 32'h40; #3;
    check("f_idle_iwait", {31'd0, iwait}, 32'd1);
    check("f_idle_ramREN", {31'd0, ramREN}, 32'd0);
    step(); ramstate = 2'd1; #3;
    check("f_g1_ramREN", {31'd0, ramREN}, 32'd1);
    check("f_g1_ramaddr", ramaddr, 32'h40);
    check("f_g1_iwait", {31'd0, iwait}, 32'd1);
    step(); ramstate = 2'd2; ramload = 32'h8C010004; #3;
    check("f_acc_iwait", {31'd0, iwait}, 32'd0);
    check("f_acc_iload", iload, 32'h8C010004);
    step(); quiet(); #3;
    check("f_after_ramREN", {31'd0, ramREN}, 32'd0);

    // Simultaneous requests: data first, then instruction after a bubble
    step(); iREN = 1; dREN = 1; daddr = 32'h80; iaddr = 32'h44; #3;
    step(); ramstate = 2'd2; #3;
    check("sim_d_ramREN", {31'd0, ramREN}, 32'd1);
    check("sim_d_ramaddr", ramaddr, 32'h80);
    check("sim_d_iwait", {31'd0, iwait}, 32'd1);
    check("sim_d_dwait", {31'd0, dwait}, 32'd0);
    step(); dREN = 0; ramstate = 2'd0; #3;
    check("sim_bubble_ramREN", {31'd0, ramREN}, 32'd0);
    step(); #3;
    check("sim_i_ramaddr", ramaddr, 32'h44);
    check("sim_i_ramREN", {31'd0, ramREN}, 32'd1);
    step(); ramstate = 2'd2; #3;
    step(); quiet(); #3;

    // Starvation: held iREN, back-to-back data writes with write-over-read
    step(); iREN = 1; dREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    iaddr = 32'h48; ramstate = 2'd2; #3;
    for (int c = 0; c < 14; c++) begin
      step(); #3;
      if (ramWEN) begin
        if (got.size() == 0) begin
          check("wr_ramREN", {31'd0, ramREN}, 32'd0);
          check("wr_ramstore", ramstore, 32'hDEADBEEF);
          check("wr_ramaddr", ramaddr, 32'h100);
        end
        got.push_back("D");
      end else if (ramREN) begin
        got.push_back("I");
      end
    end
    want = '{"D", "D", "D", "D", "I", "D"};
    check("order_len_ok", {31'd0, got.size() >= 6}, 32'd1);
    for (int k = 0; k < 6; k++)
      check($sformatf("order_%0d", k), (k < got.size()) ? {24'd0, got[k]} : 32'd0, {24'd0, want[k]});
    step(); quiet(); #3;
    step(); #3;

    // ERROR retries then ACCESS
    step(); dWEN = 1; daddr = 32'h200; dstore = 32'h12345678; #3;
    step(); ramstate = 2'd3; #3;
    check("e1_ramWEN", {31'd0, ramWEN}, 32'd1);
    check("e1_dwait", {31'd0, dwait}, 32'd1);
    check("e1_mem_err", {31'd0, mem_err}, 32'd0);
    step(); #3;
    check("e2_ramWEN", {31'd0, ramWEN}, 32'd1);
    check("e2_dwait", {31'd0, dwait}, 32'd1);
    check("e2_mem_err", {31'd0, mem_err}, 32'd1);
    step(); ramstate = 2'd2; #3;
    check("e3_ramWEN", {31'd0, ramWEN}, 32'd1);
    check("e3_dwait", {31'd0, dwait}, 32'd0);
    step(); quiet(); #3;
    check("e4_ramWEN", {31'd0, ramWEN}, 32'd0);
    check("e4_mem_err", {31'd0, mem_err}, 32'd1);

    // Reset during a busy instruction grant
    step(); iREN = 1; iaddr = 32'h60; ramstate = 2'd1; #3;
    step(); #3;
    check("r_grant_ramREN", {31'd0, ramREN}, 32'd1);
    RST = 1;
    step(); RST = 0; #3;
    check("r_ramREN", {31'd0, ramREN}, 32'd0);
    check("r_mem_err", {31'd0, mem_err}, 32'd0);
    check("r_iwait", {31'd0, iwait}, 32'd1);
    step(); #3;
    check("r_regrant_iwait", {31'd0, iwait}, 32'd1);
    step(); quiet(); #3;

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      int r;
      step();
      RST     = ($urandom_range(0, 96) == 0);
      iREN    = ($urandom_range(0, 3) != 0);
      dREN    = $urandom_range(0, 1);
      dWEN    = ($urandom_range(0, 2) == 0);
      iaddr   = $urandom;
      daddr   = $urandom;
      dstore  = $urandom;
      ramload = $urandom;
      r = $urandom_range(0, 7);
      ramstate = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
    end
    step(); RST = 0; quiet();
    step(); step();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
